reg_writeback_queue: RTL and testbench

- Write-side front end for the 32x32 register file.
- Accepts ALU results as (dest, data) pairs over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drains one entry per cycle onto the register file write port (write_enable / reg_dest / data_input).
- Provides two combinational forwarding lookups so readers see results that are still pending and not yet in the register file.

---
 rtl/reg_writeback_queue.sv | 98 +++++++++
 tb/tb_reg_writeback_queue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers ALU (dest, data) results and drains them onto the
// register file write port, forwarding pending values to readers.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_dest,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_hold,
    output logic                     rf_write_enable,
    output logic [ADDR_W-1:0]        rf_reg_dest,
    output logic [DATA_W-1:0]        rf_data_input,
    input  logic [ADDR_W-1:0]        fwd_src1,
    input  logic [ADDR_W-1:0]        fwd_src2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              push, pop;

    assign in_ready        = count_q < CW'(DEPTH);
    assign push            = in_valid && in_ready;
    assign pop             = (count_q != '0) && !drain_hold;
    assign count           = count_q;
    assign rf_write_enable = we_q;
    assign rf_reg_dest     = dest_q;
    assign rf_data_input   = data_q;

    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        we_d    = pop;
        dest_d  = pop ? dest_mem[head_q] : dest_q;
        data_d  = pop ? data_mem[head_q] : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[tail_q] <= in_dest;
            data_mem[tail_q] <= in_data;
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit1  = we_q && (dest_q == fwd_src1);
        fwd_hit2  = we_q && (dest_q == fwd_src2);
        fwd_data1 = fwd_hit1 ? data_q : '0;
        fwd_data2 = fwd_hit2 ? data_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && dest_mem[head_q + PW'(i)] == fwd_src1) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_mem[head_q + PW'(i)];
            end
            if (CW'(i) < count_q && dest_mem[head_q + PW'(i)] == fwd_src2) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_mem[head_q + PW'(i)];
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: randomized and directed scenarios checked against a
// queue-based model of the pending writes.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, drain_hold;
    logic [4:0]  in_dest, rf_reg_dest, fwd_src1, fwd_src2;
    logic [31:0] in_data, rf_data_input, fwd_data1, fwd_data2;
    logic        rf_write_enable, fwd_hit1, fwd_hit2;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {logic [4:0] d; logic [31:0] v;} ent_t;
    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
        .drain_hold(drain_hold),
        .rf_write_enable(rf_write_enable), .rf_reg_dest(rf_reg_dest), .rf_data_input(rf_data_input),
        .fwd_src1(fwd_src1), .fwd_src2(fwd_src2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
    );

    function automatic logic [32:0] fwd_model(input logic [4:0] s);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].d == s) return {1'b1, q[i].v};
        if (m_we && m_dest == s) return {1'b1, m_data};
        return 33'd0;
    endfunction

    // Advance one clock: called just after a falling edge, returns at the next one.
    task automatic step();
        bit   do_push, do_pop;
        ent_t e;
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && !drain_hold;
        e       = '{d: in_dest, v: in_data};
        @(posedge clk);
        if (do_pop) begin
            ent_t h;
            h      = q.pop_front();
            m_we   = 1'b1;
            m_dest = h.d;
            m_data = h.v;
        end else m_we = 1'b0;
        if (do_push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_we   = 1'b0;
        m_dest = '0;
        m_data = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int budget = 50;
        in_valid   = 1'b0;
        drain_hold = 1'b0;
        while ((q.size() > 0 || m_we) && budget > 0) begin
            step();
            budget--;
        end
        n_checks++;
        if (count !== 3'd0 || rf_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: count=%0d we=%0b required count=0 we=0", count, rf_write_enable);
        end
    endtask

    task automatic test_reset();
        in_valid = 0; drain_hold = 0; in_dest = 0; in_data = 0; fwd_src1 = 0; fwd_src2 = 0;
        reset_n = 1'b0;
        #3;
        n_checks++;
        if (in_ready !== 1'b1 || count !== 3'd0 || rf_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_during: ready=%0b count=%0d we=%0b required 1,0,0", in_ready, count, rf_write_enable);
        end
        apply_reset();
        #1;
        n_checks++;
        if ({in_ready, count, rf_write_enable, rf_reg_dest, rf_data_input, fwd_hit1, fwd_hit2} !== {1'b1, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_after: ready=%0b count=%0d we=%0b dest=%0d data=%h hit=%0b%0b required 1,0,0,0,0,00",
                     in_ready, count, rf_write_enable, rf_reg_dest, rf_data_input, fwd_hit1, fwd_hit2);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid = 1; in_dest = 5'd5; in_data = 32'hDEADBEEF; drain_hold = 0;
        step();
        in_valid = 0;
        n_checks++;
        if (count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_count: count=%0d required 1", count);
        end
        step();
        n_checks++;
        if ({rf_write_enable, rf_reg_dest, rf_data_input} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_write: we=%0b dest=%0d data=%h required 1,5,deadbeef", rf_write_enable, rf_reg_dest, rf_data_input);
        end
        step();
        n_checks++;
        if (rf_write_enable !== 1'b0 || count !== 3'd0 || rf_reg_dest !== 5'd5) begin
            n_fail++;
            $display("FAIL single_after: we=%0b count=%0d dest=%0d required 0,0,5", rf_write_enable, count, rf_reg_dest);
        end
    endtask

    task automatic test_full();
        drain_hold = 1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; in_dest = 5'(i); in_data = $urandom;
            step();
            if (i == 4) begin
                n_checks++;
                if (count !== 3'd4 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_fill: count=%0d ready=%0b required 4,0", count, in_ready);
                end
            end
        end
        n_checks++;
        if (count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_fifth_refused: count=%0d required 4", count);
        end
        in_valid = 0; drain_hold = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (rf_write_enable !== 1'b1 || rf_reg_dest !== 5'(i) || rf_data_input !== m_data) begin
                n_fail++;
                $display("FAIL full_drain%0d: we=%0b dest=%0d data=%h required 1,%0d,%h", i, rf_write_enable, rf_reg_dest, rf_data_input, i, m_data);
            end
        end
        n_checks++;
        if (in_ready !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL full_empty: ready=%0b count=%0d required 1,0", in_ready, count);
        end
        drain();
    endtask

    task automatic test_forward();
        drain_hold = 1;
        in_valid = 1; in_dest = 7; in_data = 32'h11; step();
        in_dest = 7; in_data = 32'h22; step();
        in_dest = 3; in_data = 32'h33; step();
        in_valid = 1; in_dest = 9; in_data = 32'h99;
        fwd_src1 = 7; fwd_src2 = 3;
        #1;
        n_checks++;
        if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 32'h22, 1'b1, 32'h33}) begin
            n_fail++;
            $display("FAIL fwd_hits: hit1=%0b d1=%h hit2=%0b d2=%h required 1,22,1,33", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
        end
        fwd_src1 = 9;
        #1;
        n_checks++;
        if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin
            n_fail++;
            $display("FAIL fwd_miss: hit1=%0b d1=%h required 0,0", fwd_hit1, fwd_data1);
        end
        in_valid = 0;
        drain();
    endtask

    task automatic test_stream();
        drain_hold = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1; in_dest = 5'($urandom); in_data = $urandom;
            step();
            n_checks++;
            if (count > 3'd1 || count !== 3'(q.size()) || rf_write_enable !== m_we ||
                (m_we && (rf_reg_dest !== m_dest || rf_data_input !== m_data))) begin
                n_fail++;
                $display("FAIL stream%0d: count=%0d we=%0b dest=%0d data=%h required %0d,%0b,%0d,%h",
                         c, count, rf_write_enable, rf_reg_dest, rf_data_input, q.size(), m_we, m_dest, m_data);
            end
        end
        drain();
    endtask

    task automatic test_full_pushpop();
        drain_hold = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_dest = 5'(10 + i); in_data = $urandom;
            step();
        end
        drain_hold = 0; in_valid = 1; in_dest = 20; in_data = 32'hCAFE;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_ready_full: ready=%0b required 0", in_ready);
        end
        step();
        n_checks++;
        if (count !== 3'd3 || rf_reg_dest !== 5'd10) begin
            n_fail++;
            $display("FAIL pp_refused: count=%0d dest=%0d required 3,10", count, rf_reg_dest);
        end
        step();
        in_valid = 0;
        n_checks++;
        if (count !== 3'd3 || q.size() != 3 || q[2].v !== 32'hCAFE || rf_reg_dest !== 5'd11) begin
            n_fail++;
            $display("FAIL pp_accepted: count=%0d dest=%0d required 3,11", count, rf_reg_dest);
        end
        drain_hold = 1;
        fwd_src1 = 20;
        #1;
        n_checks++;
        if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hCAFE) begin
            n_fail++;
            $display("FAIL pp_fwd: hit1=%0b d1=%h required 1,cafe", fwd_hit1, fwd_data1);
        end
        drain();
    endtask

    task automatic test_random();
        logic [32:0] e1, e2;
        for (int c = 0; c < 300; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            drain_hold = ($urandom_range(0, 2) == 0);
            in_dest    = 5'($urandom_range(0, 7));
            in_data    = $urandom;
            fwd_src1   = 5'($urandom_range(0, 7));
            fwd_src2   = 5'($urandom_range(0, 7));
            step();
            e1 = fwd_model(fwd_src1);
            e2 = fwd_model(fwd_src2);
            n_checks++;
            if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH) || rf_write_enable !== m_we ||
                rf_reg_dest !== m_dest || rf_data_input !== m_data ||
                {fwd_hit1, fwd_data1} !== e1 || {fwd_hit2, fwd_data2} !== e2) begin
                n_fail++;
                $display("FAIL random%0d: count=%0d we=%0b dest=%0d data=%h f1=%0b/%h f2=%0b/%h required %0d,%0b,%0d,%h,%0b/%h,%0b/%h",
                         c, count, rf_write_enable, rf_reg_dest, rf_data_input, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
                         q.size(), m_we, m_dest, m_data, e1[32], e1[31:0], e2[32], e2[31:0]);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        drain_hold = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_dest = 5'(i + 1); in_data = $urandom;
            step();
        end
        in_valid = 0; drain_hold = 0;
        step();
        n_checks++;
        if (rf_write_enable !== 1'b1 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL ar_staged: we=%0b count=%0d required 1,2", rf_write_enable, count);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (rf_write_enable !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_immediate: we=%0b count=%0d ready=%0b required 0,0,1", rf_write_enable, count, in_ready);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (rf_write_enable !== 1'b0 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL ar_after%0d: we=%0b count=%0d required 0,0", c, rf_write_enable, count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_forward();
        test_stream();
        test_full_pushpop();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
